encode_4_2_seq: RTL and testbench

//  Registered 4-to-2 priority encoder with request capture and valid/ready output.
//  - Latches request pulses on D into a sticky pending vector.
//  - Presents the index of one pending request on Y with V, and holds it until Rdy accepts it.
//  - Drives the select side feeding decode_2_4-style one-hot fan-out logic.

---
 rtl/encode_4_2_seq.sv | 113 +++++++++++
 tb/tb_encode_4_2_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/encode_4_2_seq.sv
// Registered 4-to-2 priority encoder with sticky request capture and valid/ready offer.
// Define ROUND_ROBIN_EN for rotating priority; the default is fixed highest-index priority.
module encode_4_2_seq #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] D,
  input  logic         En,
  input  logic         Rdy,
  output logic [W-1:0] Y,
  output logic         V,
  output logic [N-1:0] Pend
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] cap, clr;
  logic         accept;
  logic [W-1:0] sel;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Scan starts one past the last accepted index; W-bit addition wraps since 2**W == N.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] x, input logic [W-1:0] last);
    logic [W-1:0] r;
    logic [W-1:0] idx;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = last + W'(1) + W'(i);
      if (!found && x[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    sel   = sel_rr(pend_d, ptr_q);
    ptr_d = accept ? y_q : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x[i]) r = W'(i);
    end
    return r;
  endfunction

  always_comb begin
    sel = sel_fixed(pend_d);
  end
`endif

  always_comb begin
    cap    = En ? D : '0;
    accept = (state_q == S_OFFER) && Rdy;
    clr    = '0;
    if (accept) clr[y_q] = 1'b1;
    // Capture is OR-ed in after the clear so a same-edge re-request stays pending.
    pend_d  = (pend_q & ~clr) | cap;
    state_d = state_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (pend_d != '0) begin
          state_d = S_OFFER;
          y_d     = sel;
        end
      end
      S_OFFER: begin
        if (Rdy) begin
          if (pend_d != '0) y_d = sel;
          else              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
    end
  end

  assign Y    = y_q;
  assign V    = (state_q == S_OFFER);
  assign Pend = pend_q;

endmodule

// File: tb/tb_encode_4_2_seq.sv
// Directed self-checking bench for encode_4_2_seq; expectations are hand-computed per step.
module tb_encode_4_2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D;
  logic       En;
  logic       Rdy;
  logic [1:0] Y;
  logic       V;
  logic [3:0] Pend;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  encode_4_2_seq #(.N(4), .W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .D    (D),
    .En   (En),
    .Rdy  (Rdy),
    .Y    (Y),
    .V    (V),
    .Pend (Pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ey, input logic ev, input logic [3:0] ep);
    chk({tag, ".Y"},    32'(Y),    32'(ey));
    chk({tag, ".V"},    32'(V),    32'(ev));
    chk({tag, ".Pend"}, 32'(Pend), 32'(ep));
  endtask

  initial begin
    rst_n = 1'b0;
    D     = '0;
    En    = 1'b0;
    Rdy   = 1'b0;
    #2;
    chk_out("reset", 2'd0, 1'b0, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_reset_idle", 2'd0, 1'b0, 4'b0000);

`ifdef ROUND_ROBIN_EN
    En = 1'b1; Rdy = 1'b1; D = 4'b1111;
    tick(); D = '0;
    chk_out("rr_y0", 2'd0, 1'b1, 4'b1111);
    tick(); chk_out("rr_y1", 2'd1, 1'b1, 4'b1110);
    tick(); chk_out("rr_y2", 2'd2, 1'b1, 4'b1100);
    tick(); chk_out("rr_y3", 2'd3, 1'b1, 4'b1000);
    tick(); chk_out("rr_idle", 2'd3, 1'b0, 4'b0000);
    D = 4'b1001;
    tick(); D = '0;
    chk_out("rr_wrap_y0", 2'd0, 1'b1, 4'b1001);
    tick(); chk_out("rr_wrap_y3", 2'd3, 1'b1, 4'b1000);
    tick(); chk_out("rr_wrap_idle", 2'd3, 1'b0, 4'b0000);
`else
    // Two requests in one pulse, consumer always ready.
    En = 1'b1; Rdy = 1'b1; D = 4'b1010;
    tick(); D = '0;
    chk_out("fx_1010_y3", 2'd3, 1'b1, 4'b1010);
    tick(); chk_out("fx_1010_y1", 2'd1, 1'b1, 4'b0010);
    tick(); chk_out("fx_1010_idle", 2'd1, 1'b0, 4'b0000);

    // Higher-priority arrival while held must not disturb Y.
    Rdy = 1'b0; D = 4'b0001;
    tick(); chk_out("fx_hold_y0", 2'd0, 1'b1, 4'b0001);
    D = 4'b1000;
    tick(); D = '0;
    chk_out("fx_hold_stable", 2'd0, 1'b1, 4'b1001);
    tick(); chk_out("fx_hold_again", 2'd0, 1'b1, 4'b1001);
    Rdy = 1'b1;
    tick(); chk_out("fx_accept0_y3", 2'd3, 1'b1, 4'b1000);
    tick(); chk_out("fx_accept3_idle", 2'd3, 1'b0, 4'b0000);
`endif

    // Capture disabled.
    Rdy = 1'b0; En = 1'b0; D = 4'b1111;
    tick(); chk("en0_pend", 32'(Pend), 32'h0); chk("en0_v", 32'(V), 32'h0);
    tick(); chk("en0_pend2", 32'(Pend), 32'h0); chk("en0_v2", 32'(V), 32'h0);
    En = 1'b1; D = 4'b0100;
    tick(); D = '0;
    chk_out("en1_y2", 2'd2, 1'b1, 4'b0100);
    Rdy = 1'b1;
    tick(); chk_out("en1_accept", 2'd2, 1'b0, 4'b0000);

    // Set wins over clear on the same edge.
    Rdy = 1'b0; D = 4'b0010;
    tick(); chk_out("sw_offer1", 2'd1, 1'b1, 4'b0010);
    Rdy = 1'b1;
    tick(); D = '0;
    chk_out("sw_reoffer1", 2'd1, 1'b1, 4'b0010);
    tick(); chk_out("sw_idle", 2'd1, 1'b0, 4'b0000);

    // Asynchronous reset in the middle of an offer.
    Rdy = 1'b0; D = 4'b0100;
    tick(); D = '0;
    chk_out("mid_offer", 2'd2, 1'b1, 4'b0100);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk_out("after_async_reset", 2'd0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
